// File: rtl/rst_chk_window_ctrl_pkg.sv
// Shared state encoding and default timing for the reset/check window controller.
// Latency and flow control are defined by the modules that import this package.
package chk_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACTIVE = 2'd3
  } chk_state_e;

  localparam int DEF_HOLD_CYC   = 4;
  localparam int DEF_SETTLE_CYC = 2;

endpackage

// File: rtl/rst_chk_window_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over the increment.
// Latency: the count updates one cycle after inc is seen; no backpressure, it sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/rst_chk_window_ctrl.sv
// Sequences downstream reset through hold/settle windows, then gates checking and scores sig_in vs exp_val.
// Latency: statistics update one cycle after the sample edge; no backpressure, every active cycle is sampled.
module rst_chk_window_ctrl
  import chk_pkg::*;
#(
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int CNT_W      = 16,
  parameter int TS_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_req,
  input  logic             sig_in,
  input  logic             exp_val,
  output logic             rst_n_out,
  output logic             chk_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [TS_W-1:0]  first_fail_cyc
);

  localparam int MAX_CYC = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  chk_state_e      cur_state, nxt_state;
  logic [CW-1:0]   win_cnt, win_cnt_nxt;
  logic [TS_W-1:0] timestamp;
  logic            sample, pass_inc, fail_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_RESET;
      win_cnt   <= '0;
    end else begin
      cur_state <= nxt_state;
      win_cnt   <= win_cnt_nxt;
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    win_cnt_nxt = '0;
    rst_n_out   = 1'b0;
    chk_en      = 1'b0;
    case (cur_state)
      ST_SETTLE: rst_n_out = 1'b1;
      ST_ACTIVE: begin
        rst_n_out = 1'b1;
        chk_en    = 1'b1;
      end
      default: ;
    endcase
    // A soft request overrides any window in progress and restarts it from zero.
    if (rst_req) begin
      nxt_state = ST_RESET;
    end else begin
      case (cur_state)
        ST_RESET: nxt_state = ST_HOLD;
        ST_HOLD: begin
          if (win_cnt == HOLD_LAST) begin
            if (SETTLE_CYC == 0) nxt_state = ST_ACTIVE;
            else                 nxt_state = ST_SETTLE;
          end else begin
            win_cnt_nxt = win_cnt + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (win_cnt == SETTLE_LAST) nxt_state = ST_ACTIVE;
          else                        win_cnt_nxt = win_cnt + CW'(1);
        end
        default: nxt_state = cur_state;
      endcase
    end
  end

  assign state = cur_state;

  // A sample coinciding with either reset source is dropped, matching disable-iff semantics.
  assign sample   = (cur_state == ST_ACTIVE) && !rst && !rst_req;
  assign pass_inc = sample && (sig_in == exp_val);
  assign fail_inc = sample && (sig_in != exp_val);

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .clr (rst),
    .inc (pass_inc),
    .cnt (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .clr (rst),
    .inc (fail_inc),
    .cnt (fail_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      timestamp      <= '0;
      first_fail_vld <= 1'b0;
      first_fail_cyc <= '0;
    end else begin
      timestamp <= timestamp + TS_W'(1);
      if (fail_inc && !first_fail_vld) begin
        first_fail_vld <= 1'b1;
        first_fail_cyc <= timestamp;
      end
    end
  end

endmodule

// File: tb/tb_rst_chk_window_ctrl.sv
// Random-stimulus scoreboard bench: a default instance and a short-window, 3-bit-counter instance
// share inputs; a cycle-count model predicts every output and a monitor compares each cycle.
module tb_rst_chk_window_ctrl;

  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1, rst_req = 1'b0, sig_in = 1'b0, exp_val = 1'b0;

  logic        a_rst_n, a_chk_en, a_ffv;
  logic [1:0]  a_state;
  logic [15:0] a_pass, a_fail;
  logic [31:0] a_ffc;
  logic        b_rst_n, b_chk_en, b_ffv;
  logic [1:0]  b_state;
  logic [2:0]  b_pass, b_fail;
  logic [31:0] b_ffc;

  always #5 clk = ~clk;

  rst_chk_window_ctrl dut_a (
    .clk(clk), .rst(rst), .rst_req(rst_req), .sig_in(sig_in), .exp_val(exp_val),
    .rst_n_out(a_rst_n), .chk_en(a_chk_en), .state(a_state),
    .pass_cnt(a_pass), .fail_cnt(a_fail),
    .first_fail_vld(a_ffv), .first_fail_cyc(a_ffc)
  );

  rst_chk_window_ctrl #(.HOLD_CYC(1), .SETTLE_CYC(0), .CNT_W(3), .TS_W(32)) dut_b (
    .clk(clk), .rst(rst), .rst_req(rst_req), .sig_in(sig_in), .exp_val(exp_val),
    .rst_n_out(b_rst_n), .chk_en(b_chk_en), .state(b_state),
    .pass_cnt(b_pass), .fail_cnt(b_fail),
    .first_fail_vld(b_ffv), .first_fail_cyc(b_ffc)
  );

  // Model: 'since' counts edges since reset was released (-1 while held in reset).
  typedef struct {
    int          since;
    int unsigned pass;
    int unsigned fail;
    bit          ffv;
    logic [31:0] ffc;
    logic [31:0] ts;
  } mdl_t;

  typedef struct {
    logic [1:0]  st;
    logic        rn;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] fc;
    logic        ffv;
    logic [31:0] ffc;
  } exp_t;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic int phase_of(int since, int hold, int settle);
    if (since < 0)             return 0;
    if (since < hold)          return 1;
    if (since < hold + settle) return 2;
    return 3;
  endfunction

  function automatic void step(inout mdl_t m, input int hold, input int settle,
                               input int unsigned cmax, input bit r, input bit rq,
                               input bit s, input bit e);
    if (r) begin
      m.since = -1; m.pass = 0; m.fail = 0; m.ffv = 0; m.ffc = '0; m.ts = '0;
      return;
    end
    if (phase_of(m.since, hold, settle) == 3 && !rq) begin
      if (s == e) begin
        if (m.pass < cmax) m.pass++;
      end else begin
        if (m.fail < cmax) m.fail++;
        if (!m.ffv) begin
          m.ffv = 1;
          m.ffc = m.ts;
        end
      end
    end
    m.ts = m.ts + 32'd1;
    if (rq)                   m.since = -1;
    else if (m.since < 100000) m.since++;
  endfunction

  function automatic exp_t view(mdl_t m, int hold, int settle);
    exp_t x;
    int p;
    p     = phase_of(m.since, hold, settle);
    x.st  = 2'(p);
    x.rn  = (p >= 2);
    x.ce  = (p == 3);
    x.pc  = m.pass;
    x.fc  = m.fail;
    x.ffv = m.ffv;
    x.ffc = m.ffc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  initial begin
    exp_t ea, eb;
    forever begin
      @(posedge clk);
      #2;
      if (qa.size() == 0 || qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_state",     32'(a_state),  32'(ea.st));
        chk("a_rst_n_out", 32'(a_rst_n),  32'(ea.rn));
        chk("a_chk_en",    32'(a_chk_en), 32'(ea.ce));
        chk("a_pass_cnt",  32'(a_pass),   ea.pc);
        chk("a_fail_cnt",  32'(a_fail),   ea.fc);
        chk("a_ff_vld",    32'(a_ffv),    32'(ea.ffv));
        chk("a_ff_cyc",    a_ffc,         ea.ffc);
        chk("b_state",     32'(b_state),  32'(eb.st));
        chk("b_rst_n_out", 32'(b_rst_n),  32'(eb.rn));
        chk("b_chk_en",    32'(b_chk_en), 32'(eb.ce));
        chk("b_pass_cnt",  32'(b_pass),   eb.pc);
        chk("b_fail_cnt",  32'(b_fail),   eb.fc);
        chk("b_ff_vld",    32'(b_ffv),    32'(eb.ffv));
        chk("b_ff_cyc",    b_ffc,         eb.ffc);
      end
    end
  end

  initial begin
    int mismatch_pct;
    ma = '{since: -1, pass: 0, fail: 0, ffv: 0, ffc: '0, ts: '0};
    mb = ma;
    for (int i = 0; i < NCYC; i++) begin
      if (i > 0) @(negedge clk);
      // Mismatch density alternates so both pass and fail paths, and saturation, get exercised.
      mismatch_pct = ((i / 200) % 2 == 0) ? 10 : 50;
      if (i < 10) begin
        rst     = 1'b1;
        rst_req = 1'b0;
      end else if (i >= 400 && i < 410) begin
        rst     = 1'b0;
        rst_req = 1'b1;
      end else if (i < 400) begin
        rst     = 1'b0;
        rst_req = ($urandom_range(0, 49) == 0);
      end else begin
        rst     = ($urandom_range(0, 299) == 0);
        rst_req = ($urandom_range(0, 59) == 0);
      end
      exp_val = 1'($urandom_range(0, 1));
      sig_in  = ($urandom_range(0, 99) < mismatch_pct) ? ~exp_val : exp_val;
      step(ma, 4, 2, 32'd65535, rst, rst_req, sig_in, exp_val);
      step(mb, 1, 0, 32'd7,     rst, rst_req, sig_in, exp_val);
      qa.push_back(view(ma, 4, 2));
      qb.push_back(view(mb, 1, 0));
    end
    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
